// File: rtl/alu_pkg.sv
// Shared definitions for the gate-level ALU datapath.
package alu_pkg;
  localparam int SUB_WIDTH = 4;

  // {borrow, diff} packed so the whole subtract result moves as one value.
  typedef logic [SUB_WIDTH:0] sub_result_t;
endpackage

// File: rtl/full_substractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_substractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/substractor_4bit.sv
// 4-bit ripple-borrow subtractor with a combinational result and a
// registered copy of it for pipelined ALU paths.
module substractor_4bit
  import alu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SUB_WIDTH-1:0] i_op1,
  input  logic [SUB_WIDTH-1:0] i_op2,
  input  logic                 i_borrow,
  output logic [SUB_WIDTH-1:0] o_sub,
  output logic                 o_borrow,
  output logic [SUB_WIDTH-1:0] o_sub_q,
  output logic                 o_borrow_q
);
  // bor[k] is the borrow into bit k; bor[SUB_WIDTH] leaves the MSB cell.
  logic [SUB_WIDTH:0]   bor;
  logic [SUB_WIDTH-1:0] diff;
  sub_result_t          res_d, res_q;

  assign bor[0] = i_borrow;

  for (genvar k = 0; k < SUB_WIDTH; k++) begin : g_cell
    full_substractor u_fs (
      .a    (i_op1[k]),
      .b    (i_op2[k]),
      .bin  (bor[k]),
      .d    (diff[k]),
      .bout (bor[k+1])
    );
  end

  assign res_d    = {bor[SUB_WIDTH], diff};
  assign o_sub    = res_d[SUB_WIDTH-1:0];
  assign o_borrow = res_d[SUB_WIDTH];

  // Capture the combinational result each edge; reset clears only this copy.
  always_ff @(posedge i_clk) begin
    if (i_rst) res_q <= '0;
    else       res_q <= res_d;
  end

  assign o_sub_q    = res_q[SUB_WIDTH-1:0];
  assign o_borrow_q = res_q[SUB_WIDTH];
endmodule

// File: tb/tb_substractor_4bit.sv
// Scoreboard bench for substractor_4bit: stimulus pushes expected
// combinational and registered results; a negedge monitor pops and compares.
module tb_substractor_4bit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] op1 = '0, op2 = '0;
  logic       bin = 1'b0;
  logic [3:0] sub, sub_q;
  logic       bout, bout_q;

  typedef struct {
    logic [4:0] exp;
    int         a, b, c, r;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   reg_armed = 1'b0;

  substractor_4bit dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_op1      (op1),
    .i_op2      (op2),
    .i_borrow   (bin),
    .o_sub      (sub),
    .o_borrow   (bout),
    .o_sub_q    (sub_q),
    .o_borrow_q (bout_q)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction taken modulo 32.
  function automatic logic [4:0] ref_sub(int a, int b, int c);
    int d;
    d = a - b - c;
    return 5'(d & 31);
  endfunction

  task automatic check(string name, exp_t e, logic [4:0] act);
    n_tests++;
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: %0d-%0d-%0d rst=%0d got borrow/sub=%0d/%0d want %0d/%0d",
               name, e.a, e.b, e.c, e.r, act[4], act[3:0], e.exp[4], e.exp[3:0]);
    end
  endtask

  // Drive one vector for one clock period and queue what it should produce.
  task automatic apply(int a, int b, int c, int r);
    exp_t ec, er;
    @(posedge clk);
    #1;
    op1 = 4'(a); op2 = 4'(b); bin = 1'(c); rst = 1'(r);
    ec.a = a; ec.b = b; ec.c = c; ec.r = r;
    er = ec;
    ec.exp = ref_sub(a, b, c);
    er.exp = (r != 0) ? 5'd0 : ref_sub(a, b, c);
    comb_q.push_back(ec);
    reg_q.push_back(er);
  endtask

  // Monitor: the registered result of a vector is visible one negedge
  // after its combinational result.
  always @(negedge clk) begin
    exp_t e;
    if (reg_armed) begin
      if (reg_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL reg_underflow: got empty queue want entry");
      end else begin
        e = reg_q.pop_front();
        check("registered", e, {bout_q, sub_q});
      end
    end
    if (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      check("comb", e, {bout, sub});
      reg_armed = 1'b1;
    end else begin
      reg_armed = 1'b0;
    end
  end

  initial begin
    // Reset state of the registered pair; comb still follows inputs.
    apply(3, 9, 1, 1);
    apply(12, 4, 0, 1);
    // Directed vectors and borrow-chain extremes.
    apply(5, 3, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 0, 1, 0);
    apply(15, 15, 1, 0);
    apply(15, 0, 1, 0);
    apply(8, 8, 0, 0);
    // Registered path: 15/1 held while inputs change, then 5/0.
    apply(0, 1, 0, 0);
    apply(7, 2, 0, 0);
    apply(7, 2, 0, 0);
    // Mid-stream reset: registered 15/1 cleared, comb unaffected, then resume.
    apply(0, 1, 0, 0);
    apply(9, 4, 1, 1);
    apply(3, 5, 0, 0);
    apply(3, 5, 0, 0);
    // Exhaustive sweep.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          apply(a, b, c, 0);
    // Randomized vectors with occasional reset.
    for (int i = 0; i < 200; i++)
      apply($urandom_range(15), $urandom_range(15), $urandom_range(1),
            ($urandom_range(15) == 0) ? 1 : 0);
    repeat (4) @(posedge clk);
    n_tests++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries left want 0/0",
               comb_q.size(), reg_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
